router_output_arbiter: RTL and testbench

Output-side drainer for a router port. It watches the single-entry input buffers of N_IN router inputs and picks one non-empty buffer per cycle, round-robin. It pops the winner with a one-cycle read strobe, holds the packet in a one-entry holding register, and writes it into the downstream single-entry buffer when that buffer is not full. It is the reader/forwarder end of the buffer We/Re/full/empty protocol.

---
 rtl/router_output_arbiter.sv | 101 ++++++++++
 tb/tb_router_output_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_output_arbiter.sv
// Output-side drainer: round-robin pops one non-empty input buffer per cycle into a
// one-entry holding register and forwards it to the downstream buffer when not full.
module router_output_arbiter #(
   parameter int DATA_SIZE = 64,
   parameter int N_IN      = 4,
   parameter int PTR_W     = 3,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_IN-1:0]           in_empty,
   input  logic [N_IN*DATA_SIZE-1:0] in_data,
   output logic [N_IN-1:0]           in_Re,
   input  logic                      out_full,
   output logic                      out_We,
   output logic [DATA_SIZE-1:0]      out_data,
   output logic                      busy,
   output logic [CNT_W-1:0]          pkt_count
);

   logic [DATA_SIZE-1:0] hold_data_q, hold_data_d;
   logic                 hold_valid_q, hold_valid_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     pkt_count_q, pkt_count_d;

   logic                 space;
   logic                 found;
   logic                 accept;
   logic [PTR_W-1:0]     grant;
   logic [PTR_W-1:0]     grant_inc;
   logic [DATA_SIZE-1:0] sel_data;

   assign out_We    = hold_valid_q & ~out_full & reset;
   assign space     = ~hold_valid_q | out_We;
   assign accept    = space & found & reset;
   assign out_data  = hold_data_q;
   assign busy      = hold_valid_q;
   assign pkt_count = pkt_count_q;
   assign grant_inc = grant + 1'b1;

   // Rotating priority as two ordered passes: inputs at/after ptr first, then those before it.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (!found && !in_empty[i] && (PTR_W'(i) >= ptr_q)) begin
            found = 1'b1;
            grant = PTR_W'(i);
         end
      end
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (!found && !in_empty[i] && (PTR_W'(i) < ptr_q)) begin
            found = 1'b1;
            grant = PTR_W'(i);
         end
      end
   end

   always_comb begin
      in_Re    = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         if (grant == PTR_W'(i)) begin
            in_Re[i] = accept;
            sel_data = in_data[i*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   always_comb begin
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      ptr_d        = ptr_q;
      pkt_count_d  = pkt_count_q;
      if (accept) begin
         hold_data_d  = sel_data;
         hold_valid_d = 1'b1;
         ptr_d        = (grant_inc == PTR_W'(N_IN)) ? '0 : grant_inc;
      end else if (out_We) begin
         hold_valid_d = 1'b0;
      end
      if (out_We) begin
         pkt_count_d = pkt_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         ptr_q        <= '0;
         pkt_count_q  <= '0;
      end else begin
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         ptr_q        <= ptr_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: expected packets are queued when a grant is
// expected and popped/compared whenever the DUT writes downstream.
module tb_router_output_arbiter;

   localparam int DW = 64;
   localparam int NI = 4;

   logic              clk;
   logic              reset;
   logic [NI-1:0]     in_empty;
   logic [NI*DW-1:0]  in_data;
   logic [NI-1:0]     in_Re;
   logic              out_full;
   logic              out_We;
   logic [DW-1:0]     out_data;
   logic              busy;
   logic [15:0]       pkt_count;

   int unsigned       n_cmp = 0;
   int unsigned       n_err = 0;
   logic [DW-1:0]     sb[$];
   logic [15:0]       model_cnt = '0;
   bit                mon_en = 1'b0;

   router_output_arbiter #(
      .DATA_SIZE(64),
      .N_IN(4),
      .PTR_W(3),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_empty(in_empty),
      .in_data(in_data),
      .in_Re(in_Re),
      .out_full(out_full),
      .out_We(out_We),
      .out_data(out_data),
      .busy(busy),
      .pkt_count(pkt_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Move to the sampling point of the current cycle, check the grant, queue the popped packet.
   task automatic look(input logic [NI-1:0] exp_re, input string tag);
      @(negedge clk);
      n_cmp++;
      assert (in_Re === exp_re) else begin
         n_err++;
         $error("FAIL %s: in_Re observed=%b expected=%b", tag, in_Re, exp_re);
      end
      for (int i = 0; i < NI; i++)
         if (exp_re[i]) sb.push_back(in_data[i*DW +: DW]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setd(input int idx, input logic [DW-1:0] val);
      in_data[idx*DW +: DW] = val;
   endtask

   // Output-side scoreboard and protocol checks, every cycle once enabled.
   always @(negedge clk) begin
      if (mon_en) begin
         n_cmp++;
         assert (pkt_count === model_cnt) else begin
            n_err++;
            $error("FAIL mon_count: observed=%0d expected=%0d", pkt_count, model_cnt);
         end
         n_cmp++;
         assert (((in_Re & in_empty) === '0) && $onehot0(in_Re) && !(out_We && out_full)) else begin
            n_err++;
            $error("FAIL mon_proto: in_Re=%b in_empty=%b out_We=%b out_full=%b",
                   in_Re, in_empty, out_We, out_full);
         end
         if (!reset) begin
            n_cmp++;
            assert (out_We === 1'b0 && in_Re === '0) else begin
               n_err++;
               $error("FAIL mon_rst: out_We=%b in_Re=%b expected 0/0", out_We, in_Re);
            end
            sb.delete();
            model_cnt = '0;
         end else if (out_We === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $error("FAIL mon_dup: out_data=%h written with no packet outstanding", out_data);
            end else begin
               logic [DW-1:0] e;
               e = sb.pop_front();
               assert (out_data === e) else begin
                  n_err++;
                  $error("FAIL mon_data: observed=%h expected=%h", out_data, e);
               end
            end
            model_cnt = model_cnt + 16'd1;
         end
      end
   end

   initial begin
      reset    = 1'b0;
      out_full = 1'b0;
      in_empty = '0;
      for (int i = 0; i < NI; i++) setd(i, DW'(i));

      // Reset held for two cycles with every input non-empty.
      tick();
      look(4'b0000, "rst_re_a");
      chk("rst_we_a", DW'(out_We), '0);
      chk("rst_data_a", out_data, '0);
      chk("rst_busy_a", DW'(busy), '0);
      chk("rst_cnt_a", DW'(pkt_count), '0);
      tick();
      look(4'b0000, "rst_re_b");
      chk("rst_we_b", DW'(out_We), '0);
      tick();
      reset  = 1'b1;
      mon_en = 1'b1;

      // Single input 2.
      in_empty = 4'b1011;
      setd(2, 64'hA5A5_0000_0000_0002);
      look(4'b0100, "single_re");
      tick();
      in_empty = 4'b1111;
      look(4'b0000, "single_idle");
      chk("single_we", DW'(out_We), 64'd1);
      chk("single_data", out_data, 64'hA5A5_0000_0000_0002);
      tick();

      // ptr=3 now: only input 1 wins, ptr -> 2; then 1,2 ready picks 2; then 3 wraps ptr to 0.
      in_empty = 4'b1101;
      setd(1, 64'h1111_0000_0000_0001);
      look(4'b0010, "wrap_g1");
      chk("single_cnt", DW'(pkt_count), 64'd1);
      tick();
      in_empty = 4'b1001;
      setd(2, 64'h2222_0000_0000_0002);
      look(4'b0100, "ptr_is_2");
      tick();
      in_empty = 4'b0111;
      setd(3, 64'h3333_0000_0000_0003);
      look(4'b1000, "wrap_g3");
      tick();
      in_empty = 4'b0110;
      setd(0, 64'h4444_0000_0000_0000);
      look(4'b0001, "ptr_is_0");
      tick();
      in_empty = 4'b1111;
      look(4'b0000, "drain_a");
      tick();

      // Fairness from a fresh pointer.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      in_empty = 4'b0000;
      for (int i = 0; i < NI; i++) setd(i, DW'(i));
      for (int c = 0; c < 8; c++) begin
         look(4'b0001 << (c % 4), "fair_re");
         chk("fair_we", DW'(out_We), (c == 0) ? 64'd0 : 64'd1);
         tick();
      end
      in_empty = 4'b1111;
      look(4'b0000, "drain_b");
      tick();

      // Backpressure.
      in_empty = 4'b1100;
      out_full = 1'b1;
      setd(0, 64'hDEAD_0000_0000_0000);
      setd(1, 64'hBEEF_0000_0000_0001);
      look(4'b0001, "bp_first");
      tick();
      for (int c = 0; c < 4; c++) begin
         look(4'b0000, "bp_hold_re");
         chk("bp_busy", DW'(busy), 64'd1);
         chk("bp_data", out_data, 64'hDEAD_0000_0000_0000);
         tick();
      end
      out_full = 1'b0;
      look(4'b0010, "bp_release_re");
      chk("bp_release_we", DW'(out_We), 64'd1);
      tick();
      in_empty = 4'b1111;
      look(4'b0000, "bp_after");
      chk("bp_next_data", out_data, 64'hBEEF_0000_0000_0001);
      tick();

      // Reset mid-flight discards the held packet.
      in_empty = 4'b1110;
      setd(0, 64'h5555_0000_0000_0000);
      look(4'b0001, "mid_load");
      tick();
      out_full = 1'b1;
      reset    = 1'b0;
      look(4'b0000, "mid_rst_re");
      chk("mid_busy_before", DW'(busy), 64'd1);
      tick();
      reset    = 1'b1;
      in_empty = 4'b1111;
      look(4'b0000, "mid_after_re");
      chk("mid_busy", DW'(busy), '0);
      chk("mid_we", DW'(out_We), '0);
      chk("mid_cnt", DW'(pkt_count), '0);
      tick();

      // Forward exactly 2^16 packets back to back; the counter returns to 0.
      out_full = 1'b0;
      in_empty = 4'b1110;
      for (int k = 0; k < 65536; k++) begin
         setd(0, {32'hC0DE_0000, 32'(k)});
         look(4'b0001, "cnt_re");
         tick();
      end
      in_empty = 4'b1111;
      look(4'b0000, "cnt_drain");
      chk("cnt_ffff", DW'(pkt_count), 64'hFFFF);
      tick();
      look(4'b0000, "cnt_idle");
      chk("cnt_wrap", DW'(pkt_count), '0);
      chk("sb_empty", DW'(sb.size()), '0);
      tick();

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
